// File: rtl/t_pulse_pkg.sv
// Shared constants for the toggle-request generator that drives t_ff.t.
package t_pulse_pkg;
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PERIOD_W   = 8;
  localparam int TCNT_W         = 8;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module btn_debounce
  import t_pulse_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             btn_s1;
  logic             btn_s2;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_db  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_MAX) begin
        // The DEB_CYCLES-th consecutive differing cycle commits the new level.
        btn_db  <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/t_pulse_gen.sv
// Debounced push-button toggles plus optional periodic auto toggles,
// merged into a single registered t_out pulse with a wrapping event count.
module t_pulse_gen
  import t_pulse_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PERIOD_W   = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                t_out,
  output logic [TCNT_W-1:0]   toggle_cnt
);

  logic                btn_db;
  logic                btn_db_d;
  logic [PERIOD_W-1:0] auto_cnt;
  logic                man_ev;
  logic                auto_on;
  logic                auto_ev;
  logic                any_ev;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .btn_db(btn_db)
  );

  // Only a press (rising debounced edge) requests a toggle.
  assign man_ev  = btn_db & ~btn_db_d;
  assign auto_on = auto_en && (period != '0);
  // >= rather than == so a period shrink below the running count fires at once.
  assign auto_ev = auto_on && (auto_cnt >= (period - PERIOD_W'(1)));
  assign any_ev  = man_ev | auto_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_d   <= 1'b0;
      auto_cnt   <= '0;
      t_out      <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      btn_db_d <= btn_db;
      t_out    <= any_ev;
      if (any_ev) begin
        toggle_cnt <= toggle_cnt + TCNT_W'(1);
      end
      if (!auto_on || auto_ev) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed and randomized bench for t_pulse_gen against a behavioural model.
module tb_t_pulse_gen;

  localparam int DEB = 4;
  localparam int PW  = 8;

  logic          clk_tb;
  logic          rst;
  logic          btn_in;
  logic          auto_en;
  logic [PW-1:0] period;
  logic          t_out;
  logic [7:0]    toggle_cnt;

  int total = 0;
  int bad   = 0;

  t_pulse_gen #(
    .DEB_CYCLES(DEB),
    .PERIOD_W  (PW)
  ) dut (
    .clk       (clk_tb),
    .rst       (rst),
    .btn_in    (btn_in),
    .auto_en   (auto_en),
    .period    (period),
    .t_out     (t_out),
    .toggle_cnt(toggle_cnt)
  );

  // Clock / reset
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Behavioural model: sampled button history, run-length debounce,
  // cycles-since-last-auto-pulse phase and an event tally.
  bit m_pipe[$];
  bit m_db;
  bit m_db_prev;
  int m_streak;
  int m_phase;
  bit m_t;
  int m_cnt;

  // Observation bookkeeping for directed sections
  int edge_n   = 0;
  int pulses   = 0;
  int first_hi = -1;

  task automatic model_reset();
    m_pipe    = {1'b0, 1'b0};
    m_db      = 1'b0;
    m_db_prev = 1'b0;
    m_streak  = 0;
    m_phase   = 0;
    m_t       = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic model_edge();
    bit s2;
    bit press;
    bit fire;
    if (rst) begin
      model_reset();
      return;
    end
    s2    = m_pipe[0];
    press = m_db && !m_db_prev;
    fire  = auto_en && (period != 0) && (m_phase >= int'(period) - 1);
    m_t   = press || fire;
    if (m_t) m_cnt = (m_cnt + 1) % 256;
    m_db_prev = m_db;
    if (s2 != m_db) begin
      m_streak++;
      if (m_streak == DEB) begin
        m_db     = s2;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    if (!auto_en || period == 0 || fire) m_phase = 0;
    else m_phase++;
    void'(m_pipe.pop_front());
    m_pipe.push_back(btn_in);
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock edge, model update, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk_tb);
    model_edge();
    edge_n++;
    #1;
    chk("t_out_model", {31'b0, t_out}, {31'b0, m_t});
    chk("cnt_model", {24'b0, toggle_cnt}, m_cnt);
    if (t_out === 1'b1) begin
      pulses++;
      if (first_hi < 0) first_hi = edge_n;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    pulses   = 0;
    first_hi = -1;
  endtask

  initial begin
    int start;
    int cnt0;
    logic [4:0] shrink_exp;

    // Power-on reset
    rst     = 1'b1;
    btn_in  = 1'b0;
    auto_en = 1'b0;
    period  = '0;
    model_reset();
    #1;
    chk("reset_t_out", {31'b0, t_out}, 0);
    chk("reset_cnt", {24'b0, toggle_cnt}, 0);
    ticks(2);
    rst = 1'b0;
    ticks(3);

    // Manual press held 20 cycles: one pulse, 6 edges after first sample
    clear_obs();
    btn_in = 1'b1;
    start  = edge_n + 1;
    ticks(20);
    chk("press_pulses", pulses, 1);
    chk("press_latency", first_hi - start, 6);
    chk("press_cnt", {24'b0, toggle_cnt}, 1);
    clear_obs();
    btn_in = 1'b0;
    ticks(15);
    chk("release_pulses", pulses, 0);

    // Bounce: three 2-cycle blips, then stable high
    clear_obs();
    for (int b = 0; b < 3; b++) begin
      btn_in = 1'b1;
      ticks(2);
      btn_in = 1'b0;
      ticks(3);
    end
    btn_in = 1'b1;
    start  = edge_n + 1;
    ticks(20);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_latency", first_hi - start, 6);
    btn_in = 1'b0;
    ticks(15);

    // Auto period 3 for 30 cycles
    clear_obs();
    cnt0    = toggle_cnt;
    period  = 8'd3;
    auto_en = 1'b1;
    start   = edge_n + 1;
    ticks(30);
    chk("auto3_pulses", pulses, 10);
    chk("auto3_first", first_hi - start, 2);
    chk("auto3_cnt", {24'b0, toggle_cnt}, (cnt0 + 10) % 256);
    auto_en = 1'b0;
    tick();
    chk("auto_off_t_out", {31'b0, t_out}, 0);

    // Period 0 disables auto pulses
    clear_obs();
    auto_en = 1'b1;
    period  = 8'd0;
    ticks(10);
    chk("period0_pulses", pulses, 0);

    // Period 1: t_out continuously high
    clear_obs();
    period = 8'd1;
    ticks(10);
    chk("period1_pulses", pulses, 10);
    chk("period1_t_out", {31'b0, t_out}, 1);

    // Asynchronous reset while t_out is high
    rst = 1'b1;
    #1;
    chk("async_rst_t_out", {31'b0, t_out}, 0);
    chk("async_rst_cnt", {24'b0, toggle_cnt}, 0);
    model_reset();
    auto_en = 1'b0;
    ticks(2);
    rst = 1'b0;
    clear_obs();
    ticks(10);
    chk("post_rst_pulses", pulses, 0);

    // Count wrap: 260 cycles at period 1
    auto_en = 1'b1;
    period  = 8'd1;
    ticks(260);
    chk("wrap_cnt", {24'b0, toggle_cnt}, 4);
    auto_en = 1'b0;
    ticks(3);

    // Collision: manual and auto events land on the same edge
    clear_obs();
    cnt0    = toggle_cnt;
    btn_in  = 1'b1;
    auto_en = 1'b1;
    period  = 8'd7;
    start   = edge_n + 1;
    ticks(7);
    chk("collide_pulses", pulses, 1);
    chk("collide_edge", first_hi - start, 6);
    chk("collide_cnt", {24'b0, toggle_cnt}, (cnt0 + 1) % 256);
    auto_en = 1'b0;
    btn_in  = 1'b0;
    ticks(15);

    // Period shrink 10 -> 2 with auto_cnt at 5
    auto_en = 1'b1;
    period  = 8'd10;
    ticks(5);
    period     = 8'd2;
    shrink_exp = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("shrink_seq", {31'b0, t_out}, {31'b0, shrink_exp[4-k]});
    end
    auto_en = 1'b0;
    ticks(2);

    // Randomized mix against the model
    for (int seg = 0; seg < 60; seg++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) auto_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) period = 8'($urandom_range(0, 12));
      ticks($urandom_range(1, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t_pulse_gen.md
# t_pulse_gen

Toggle-request generator that sits directly upstream of the `t_ff` stage and drives its `t` input. It turns an asynchronous push-button into a debounced, single-cycle toggle pulse. It can also generate periodic toggle pulses on its own (auto mode), so the downstream flip-flop divides by a programmable period. A wrapping 8-bit count of issued toggles is provided for observability.

## Interface
- `DEB_CYCLES`, default 4: consecutive cycles `btn_s2` must differ from the debounced state before that state changes; legal range ≥ 1.
- `PERIOD_W`, default 8: width of the `period` input.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `btn_in`  input  1  raw asynchronous button level.
- `auto_en`  input  1  synchronous enable for periodic toggling.
- `period`  input  PERIOD_W  auto-toggle period in cycles; 0 disables auto pulses.
- `t_out`  output  1  registered toggle pulse, connected to `t_ff.t`.
- `toggle_cnt`  output  8  number of cycles in which `t_out` was 1, modulo 256.

## Operation
- **Synchronizer:** two flops, `btn_in` → `btn_s1` → `btn_s2`.
- **Debounce:** holds a stable state `btn_db` and a counter `deb_cnt`.
  - If `btn_s2 == btn_db`: `deb_cnt` ← 0.
  - If they differ and `deb_cnt < DEB_CYCLES-1`: `deb_cnt` increments.
  - If they differ and `deb_cnt == DEB_CYCLES-1`: `btn_db` ← `btn_s2` and `deb_cnt` ← 0.
- **Manual event:** `man_ev = btn_db & ~btn_db_d`, a rising edge of the debounced state only. A release produces no event.
- **Auto counter `auto_cnt`** (PERIOD_W bits):
  - When `auto_en=0` or `period=0`: held at 0 and no auto event.
  - Otherwise `auto_ev = (auto_cnt >= period-1)`. On `auto_ev`, `auto_cnt` ← 0; otherwise it increments.
  - The `>=` comparison makes a shrink of `period` mid-count fire on the next cycle instead of waiting for a wrap.
- **Output register:** `t_out` ← `man_ev | auto_ev`. A manual and an auto event in the same cycle produce one pulse, not two, and a count of +1.
- **Toggle count:** `toggle_cnt` increments at every posedge where `man_ev | auto_ev` is 1, so it updates on the same edge that raises `t_out`. It wraps 255 → 0.
- **Reset values:** `t_out=0`, `toggle_cnt=0`. All internal flops are 0: `btn_s1`, `btn_s2`, `btn_db`, `btn_db_d`, `deb_cnt`, `auto_cnt`.
- **Reset mid-operation:** outputs clear immediately (asynchronous). After release, a button already held high gives exactly one pulse once it has been synchronized and debounced.

## Timing
- **Manual latency:** from the first posedge that samples `btn_in=1` to `t_out=1` is `DEB_CYCLES+2` posedges (6 with the default), provided `btn_in` stays high.
- **Manual pulse width:** `t_out` is high for exactly 1 cycle per press, however long the button is held.
- **Glitch rejection:** a `btn_s2` excursion shorter than `DEB_CYCLES` cycles produces no pulse and leaves `btn_db` unchanged.
- **Auto start:** with `auto_en` rising and `auto_cnt=0`, the first `t_out` high follows the `period`-th posedge. After that, one pulse every `period` cycles.
- **period=1:** `t_out` stays high continuously, and `toggle_cnt` increments every cycle.
- **auto_en falling:** `auto_cnt` clears on the next posedge. A pulse already registered in `t_out` completes its one cycle.

## Structure
- **Package `t_pulse_pkg`:** default `DEB_CYCLES` and `PERIOD_W` constants, and `TCNT_W = 8`.
- **Sub-module `btn_debounce`:** contains the synchronizer and debounce counter.
  - Ports: `clk`, `rst`, `btn_in`, `btn_db`.
  - Parameterized by `DEB_CYCLES`.
- **Top-level logic:** edge detect, auto counter, output register and toggle count.

## Test plan
- **Reset:** assert `rst` mid-stream with `t_out=1` → `t_out=0` and `toggle_cnt=0` without waiting for a clock edge; after release, no spurious pulse.
- **Manual press:** `DEB_CYCLES=4`, `btn_in` high for 20 cycles → exactly one `t_out` pulse 6 posedges after the first sampling edge; `toggle_cnt=1`; release gives no pulse.
- **Bounce:** `btn_in` pulses high for 2 cycles three times, then holds high → only one pulse, timed from the start of the final stable high.
- **Auto mode:** `auto_en=1`, `period=3` for 30 cycles → pulses every 3rd cycle; `toggle_cnt=10`. `period=0` → no pulses. `period=1` → `t_out` constant high.
- **Collision and wrap:** a manual event on the same cycle as an auto event → single pulse, count +1. Run `period=1` for 260 cycles → `toggle_cnt` wraps to 4.
- **Period shrink:** change `period` from 10 to 2 while `auto_cnt=5` → pulse on the next posedge, then every 2 cycles.
